// File: rtl/sa_pkg.sv
// Shared types for the split-aware AXI read-data path: split-info FIFO entry and R beat.
// Struct widths follow the SA_* constants; the top-level parameters default to them.
package sa_pkg;
  localparam int SA_MST_AMT        = 4;
  localparam int SA_MST_ID_W       = $clog2(SA_MST_AMT);
  localparam int SA_DATA_WIDTH     = 64;
  localparam int SA_TRANS_MST_ID_W = 5;
  localparam int SA_TRANS_SLV_ID_W = SA_TRANS_MST_ID_W + SA_MST_ID_W;
  localparam int SA_TRANS_RESP_W   = 2;
  localparam int SA_MAX_SPLIT      = 4;
  localparam int SA_SPLIT_CNT_W    = (SA_MAX_SPLIT > 2) ? $clog2(SA_MAX_SPLIT) : 1;

  typedef struct packed {
    logic [SA_SPLIT_CNT_W-1:0]    split_cnt;
    logic [SA_TRANS_SLV_ID_W-1:0] axid;
  } sa_split_info_t;

  typedef struct packed {
    logic [SA_TRANS_SLV_ID_W-1:0] rid;
    logic [SA_DATA_WIDTH-1:0]     rdata;
    logic [SA_TRANS_RESP_W-1:0]   rresp;
    logic                         rlast;
  } sa_r_beat_t;
endpackage

// File: rtl/sa_r_split_tracker.sv
// Outstanding-AR info FIFO plus sub-burst counter; decides whether an RLAST closes the head AR.
// With SA_R_ID_CHECK_EN the head AxID and its validity are exported for the ID check.
module sa_r_split_tracker
  import sa_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic           ACLK_i,
  input  logic           ARESETn_i,
  input  logic           push_i,
  input  sa_split_info_t push_info_i,
  input  logic           pop_i,
  output logic           full_o,
  output logic           last_ok_o
`ifdef SA_R_ID_CHECK_EN
  ,
  output logic                         head_valid_o,
  output logic [SA_TRANS_SLV_ID_W-1:0] head_id_o
`endif
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  sa_split_info_t             r_mem [DEPTH];
  logic [PTR_W-1:0]           r_wr_ptr;
  logic [PTR_W-1:0]           r_rd_ptr;
  logic [CNT_W-1:0]           r_count;
  logic [SA_SPLIT_CNT_W-1:0]  r_sub_idx;
  logic [SA_SPLIT_CNT_W-1:0]  w_head_cnt;
  logic                       w_empty;
  logic                       w_last_sub;
  logic                       w_push;
  logic                       w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_head_cnt = r_mem[r_rd_ptr].split_cnt;
  assign w_empty    = (r_count == '0);
  assign full_o     = (r_count == CNT_W'(DEPTH));
  assign w_last_sub = (r_sub_idx == w_head_cnt);
  assign last_ok_o  = w_empty | w_last_sub;
  // A push while full is dropped even if a pop frees a slot in the same cycle.
  assign w_push     = push_i & ~full_o;
  assign w_pop      = pop_i & ~w_empty & w_last_sub;

`ifdef SA_R_ID_CHECK_EN
  assign head_valid_o = ~w_empty;
  assign head_id_o    = r_mem[r_rd_ptr].axid;
`endif

  always_ff @(posedge ACLK_i) begin
    if (w_push) r_mem[r_wr_ptr] <= push_info_i;
  end

  always_ff @(posedge ACLK_i) begin
    if (!ARESETn_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_sub_idx <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (pop_i && !w_empty) r_sub_idx <= w_last_sub ? '0 : r_sub_idx + 1'b1;
    end
  end
endmodule

// File: rtl/sa_rdata_channel_split.sv
// Slave R channel -> 2-entry pipelined skid buffer -> per-master dispatch with split-aware RLAST.
// Optional macro SA_R_ID_CHECK_EN adds the RID/head-AxID check and err_id_mismatch_o.
module sa_rdata_channel_split
  import sa_pkg::*;
#(
  parameter int MST_AMT         = SA_MST_AMT,
  parameter int OUTSTANDING_AMT = 8,
  parameter int MST_ID_W        = $clog2(MST_AMT),
  parameter int DATA_WIDTH      = SA_DATA_WIDTH,
  parameter int TRANS_MST_ID_W  = SA_TRANS_MST_ID_W,
  parameter int TRANS_SLV_ID_W  = TRANS_MST_ID_W + MST_ID_W,
  parameter int TRANS_RESP_W    = SA_TRANS_RESP_W,
  parameter int MAX_SPLIT       = SA_MAX_SPLIT,
  parameter int SPLIT_CNT_W     = (MAX_SPLIT > 2) ? $clog2(MAX_SPLIT) : 1
) (
  input  logic                               ACLK_i,
  input  logic                               ARESETn_i,
  input  logic [TRANS_SLV_ID_W-1:0]          s_RID_i,
  input  logic [DATA_WIDTH-1:0]              s_RDATA_i,
  input  logic [TRANS_RESP_W-1:0]            s_RRESP_i,
  input  logic                               s_RLAST_i,
  input  logic                               s_RVALID_i,
  output logic                               s_RREADY_o,
  input  logic [MST_AMT-1:0]                 dsp_RREADY_i,
  output logic [TRANS_MST_ID_W*MST_AMT-1:0]  dsp_RID_o,
  output logic [DATA_WIDTH*MST_AMT-1:0]      dsp_RDATA_o,
  output logic [TRANS_RESP_W*MST_AMT-1:0]    dsp_RRESP_o,
  output logic [MST_AMT-1:0]                 dsp_RLAST_o,
  output logic [MST_AMT-1:0]                 dsp_RVALID_o,
  input  logic [TRANS_SLV_ID_W-1:0]          AR_AxID_i,
  input  logic [SPLIT_CNT_W-1:0]             AR_split_cnt_i,
  input  logic                               AR_shift_en_i,
  output logic                               AR_stall_o
`ifdef SA_R_ID_CHECK_EN
  ,
  output logic                               err_id_mismatch_o
`endif
);
  sa_r_beat_t           r_buf [2];
  sa_r_beat_t           w_in_beat;
  sa_r_beat_t           w_fwd;
  sa_split_info_t       w_push_info;
  logic                 r_wr_sel;
  logic                 r_rd_sel;
  logic                 r_s_rready;
  logic [1:0]           r_cnt;
  logic [1:0]           w_cnt_next;
  logic                 w_in_hs;
  logic                 w_fwd_valid;
  logic                 w_fwd_ready;
  logic                 w_out_hs;
  logic                 w_last_ok;
  logic [MST_ID_W-1:0]  w_mst_id;
  logic [MST_AMT-1:0]   w_mst_hit;

  assign w_in_beat   = '{rid: s_RID_i, rdata: s_RDATA_i, rresp: s_RRESP_i, rlast: s_RLAST_i};
  assign w_push_info = '{split_cnt: AR_split_cnt_i, axid: AR_AxID_i};
  assign w_in_hs     = s_RVALID_i & r_s_rready;
  assign w_fwd_valid = (r_cnt != 2'd0);
  assign w_fwd       = r_buf[r_rd_sel];
  assign w_out_hs    = w_fwd_valid & w_fwd_ready;
  assign s_RREADY_o  = r_s_rready;

  always_comb begin
    w_cnt_next = r_cnt;
    case ({w_in_hs, w_out_hs})
      2'b10:   w_cnt_next = r_cnt + 2'd1;
      2'b01:   w_cnt_next = r_cnt - 2'd1;
      default: w_cnt_next = r_cnt;
    endcase
  end

  always_ff @(posedge ACLK_i) begin
    if (w_in_hs) r_buf[r_wr_sel] <= w_in_beat;
  end

  // Ready is registered from the next occupancy, so it never admits a third beat.
  always_ff @(posedge ACLK_i) begin
    if (!ARESETn_i) begin
      r_wr_sel   <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_cnt      <= 2'd0;
      r_s_rready <= 1'b1;
    end else begin
      if (w_in_hs)  r_wr_sel <= ~r_wr_sel;
      if (w_out_hs) r_rd_sel <= ~r_rd_sel;
      r_cnt      <= w_cnt_next;
      r_s_rready <= (w_cnt_next < 2'd2);
    end
  end

  assign w_mst_id = w_fwd.rid[TRANS_SLV_ID_W-1 -: MST_ID_W];
  // Beats addressed to a non-existent master are sunk so the slave never deadlocks.
  assign w_fwd_ready = (|w_mst_hit) ? |(w_mst_hit & dsp_RREADY_i) : 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < MST_AMT; gi++) begin : g_mst
      assign w_mst_hit[gi]    = (w_mst_id == MST_ID_W'(gi));
      assign dsp_RVALID_o[gi] = w_fwd_valid & w_mst_hit[gi];
      assign dsp_RLAST_o[gi]  = w_fwd_valid & w_fwd.rlast & w_last_ok;
      assign dsp_RID_o[gi*TRANS_MST_ID_W +: TRANS_MST_ID_W] = w_fwd.rid[TRANS_MST_ID_W-1:0];
      assign dsp_RDATA_o[gi*DATA_WIDTH +: DATA_WIDTH]       = w_fwd.rdata;
      assign dsp_RRESP_o[gi*TRANS_RESP_W +: TRANS_RESP_W]   = w_fwd.rresp;
    end
  endgenerate

`ifdef SA_R_ID_CHECK_EN
  logic                         w_head_valid;
  logic [SA_TRANS_SLV_ID_W-1:0] w_head_id;
  logic                         r_err_id_mismatch;
`endif

  sa_r_split_tracker #(
    .DEPTH(OUTSTANDING_AMT)
  ) u_tracker (
    .ACLK_i       (ACLK_i),
    .ARESETn_i    (ARESETn_i),
    .push_i       (AR_shift_en_i),
    .push_info_i  (w_push_info),
    .pop_i        (w_out_hs & w_fwd.rlast),
    .full_o       (AR_stall_o),
    .last_ok_o    (w_last_ok)
`ifdef SA_R_ID_CHECK_EN
    ,
    .head_valid_o (w_head_valid),
    .head_id_o    (w_head_id)
`endif
  );

`ifdef SA_R_ID_CHECK_EN
  always_ff @(posedge ACLK_i) begin
    if (!ARESETn_i) r_err_id_mismatch <= 1'b0;
    else r_err_id_mismatch <= w_out_hs & w_head_valid & (w_fwd.rid != w_head_id);
  end
  assign err_id_mismatch_o = r_err_id_mismatch;
`endif
endmodule

// File: tb/tb_sa_rdata_channel_split.sv
// Directed scoreboard bench for sa_rdata_channel_split (second instance uses MST_AMT=3).
// The ID-check pulse is exercised only when SA_R_ID_CHECK_EN is defined.
module tb_sa_rdata_channel_split;
  logic        clk = 1'b0;
  logic        ARESETn_i;
  logic [6:0]  s_RID_i;
  logic [63:0] s_RDATA_i;
  logic [1:0]  s_RRESP_i;
  logic        s_RLAST_i, s_RVALID_i, s_RREADY_o;
  logic [3:0]  dsp_RREADY_i;
  logic [19:0] dsp_RID_o;
  logic [255:0] dsp_RDATA_o;
  logic [7:0]  dsp_RRESP_o;
  logic [3:0]  dsp_RLAST_o, dsp_RVALID_o;
  logic [6:0]  AR_AxID_i;
  logic [1:0]  AR_split_cnt_i;
  logic        AR_shift_en_i, AR_stall_o;
  logic        err_id_mismatch_o;

  logic [6:0]  b_s_RID_i;
  logic [63:0] b_s_RDATA_i;
  logic [1:0]  b_s_RRESP_i;
  logic        b_s_RLAST_i, b_s_RVALID_i, b_s_RREADY_o;
  logic [2:0]  b_dsp_RREADY_i;
  logic [14:0] b_dsp_RID_o;
  logic [191:0] b_dsp_RDATA_o;
  logic [5:0]  b_dsp_RRESP_o;
  logic [2:0]  b_dsp_RLAST_o, b_dsp_RVALID_o;
  logic        b_AR_stall_o;
  logic        b_err_id_mismatch_o;

  always #5 clk = ~clk;

  sa_rdata_channel_split dut (
    .ACLK_i(clk), .ARESETn_i(ARESETn_i),
    .s_RID_i(s_RID_i), .s_RDATA_i(s_RDATA_i), .s_RRESP_i(s_RRESP_i),
    .s_RLAST_i(s_RLAST_i), .s_RVALID_i(s_RVALID_i), .s_RREADY_o(s_RREADY_o),
    .dsp_RREADY_i(dsp_RREADY_i), .dsp_RID_o(dsp_RID_o), .dsp_RDATA_o(dsp_RDATA_o),
    .dsp_RRESP_o(dsp_RRESP_o), .dsp_RLAST_o(dsp_RLAST_o), .dsp_RVALID_o(dsp_RVALID_o),
    .AR_AxID_i(AR_AxID_i), .AR_split_cnt_i(AR_split_cnt_i),
    .AR_shift_en_i(AR_shift_en_i), .AR_stall_o(AR_stall_o)
`ifdef SA_R_ID_CHECK_EN
    , .err_id_mismatch_o(err_id_mismatch_o)
`endif
  );

  sa_rdata_channel_split #(.MST_AMT(3)) dut_b (
    .ACLK_i(clk), .ARESETn_i(ARESETn_i),
    .s_RID_i(b_s_RID_i), .s_RDATA_i(b_s_RDATA_i), .s_RRESP_i(b_s_RRESP_i),
    .s_RLAST_i(b_s_RLAST_i), .s_RVALID_i(b_s_RVALID_i), .s_RREADY_o(b_s_RREADY_o),
    .dsp_RREADY_i(b_dsp_RREADY_i), .dsp_RID_o(b_dsp_RID_o), .dsp_RDATA_o(b_dsp_RDATA_o),
    .dsp_RRESP_o(b_dsp_RRESP_o), .dsp_RLAST_o(b_dsp_RLAST_o), .dsp_RVALID_o(b_dsp_RVALID_o),
    .AR_AxID_i(7'd0), .AR_split_cnt_i(2'd0), .AR_shift_en_i(1'b0), .AR_stall_o(b_AR_stall_o)
`ifdef SA_R_ID_CHECK_EN
    , .err_id_mismatch_o(b_err_id_mismatch_o)
`endif
  );

`ifndef SA_R_ID_CHECK_EN
  assign err_id_mismatch_o   = 1'b0;
  assign b_err_id_mismatch_o = 1'b0;
`endif

  typedef struct {
    int          mst;
    logic [4:0]  rid_lo;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        rlast;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   st_from = -1, st_to = -1, st_m = 0;
  bit   saw_low = 0;
  logic cur_exp_rlast = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: record input acceptance, then compare the beat the DUT now presents.
  task automatic step(output bit acc);
    exp_t e;
    acc = s_RVALID_i && s_RREADY_o;
    @(posedge clk); #1;
    cyc++;
    if (acc) begin
      e.mst = int'(s_RID_i[6:5]); e.rid_lo = s_RID_i[4:0];
      e.data = s_RDATA_i; e.resp = s_RRESP_i; e.rlast = cur_exp_rlast;
      q.push_back(e);
    end
    dsp_RREADY_i = 4'hF;
    if (cyc >= st_from && cyc < st_to) dsp_RREADY_i[st_m] = 1'b0;
    if (!s_RREADY_o) saw_low = 1;
    check("s_rready", {63'd0, s_RREADY_o}, {63'd0, q.size() < 2});
    if (q.size() != 0) begin
      e = q[0];
      check("rvalid", {60'd0, dsp_RVALID_o}, 64'd1 << e.mst);
      check("rid", {59'd0, dsp_RID_o[e.mst*5 +: 5]}, {59'd0, e.rid_lo});
      check("rdata", dsp_RDATA_o[e.mst*64 +: 64], e.data);
      check("rresp", {62'd0, dsp_RRESP_o[e.mst*2 +: 2]}, {62'd0, e.resp});
      check("rlast", {63'd0, dsp_RLAST_o[e.mst]}, {63'd0, e.rlast});
      if (dsp_RREADY_i[e.mst]) begin
        $display("beat mst=%0d rid=%02h data=%016h last=%0b", e.mst, e.rid_lo, e.data, e.rlast);
        void'(q.pop_front());
      end
    end else begin
      check("rvalid_idle", {60'd0, dsp_RVALID_o}, 64'd0);
    end
  endtask

  task automatic push_ar(input logic [6:0] id, input logic [1:0] cnt);
    bit a;
    AR_AxID_i = id; AR_split_cnt_i = cnt; AR_shift_en_i = 1'b1;
    step(a);
    AR_shift_en_i = 1'b0;
  endtask

  task automatic drain();
    bit a;
    step(a);
    for (int i = 0; i < 30 && q.size() != 0; i++) step(a);
    check("drain", 64'(q.size()), 64'd0);
  endtask

  task automatic send(input logic [6:0] rid, input int n, input int sub_len, input bit final_only);
    bit a;
    for (int b = 0; b < n; b++) begin
      s_RID_i = rid; s_RDATA_i = {$urandom, $urandom}; s_RRESP_i = 2'(b);
      s_RLAST_i = ((b + 1) % sub_len == 0);
      cur_exp_rlast = final_only ? (b == n - 1) : s_RLAST_i;
      s_RVALID_i = 1'b1;
      a = 0;
      for (int g = 0; g < 50 && !a; g++) step(a);
      check("accept", {63'd0, a}, 64'd1);
    end
    s_RVALID_i = 1'b0;
    drain();
  endtask

  initial begin
    bit a;
    ARESETn_i = 1'b0; s_RID_i = '0; s_RDATA_i = '0; s_RRESP_i = '0; s_RLAST_i = 0; s_RVALID_i = 0;
    dsp_RREADY_i = 4'hF; AR_AxID_i = '0; AR_split_cnt_i = '0; AR_shift_en_i = 0;
    b_s_RID_i = '0; b_s_RDATA_i = '0; b_s_RRESP_i = '0; b_s_RLAST_i = 0; b_s_RVALID_i = 0;
    b_dsp_RREADY_i = 3'b111;
    repeat (3) @(posedge clk);
    #1 ARESETn_i = 1'b1;
    check("rst_sready", {63'd0, s_RREADY_o}, 64'd1);
    check("rst_rvalid", {60'd0, dsp_RVALID_o}, 64'd0);
    check("rst_rlast", {60'd0, dsp_RLAST_o}, 64'd0);
    check("rst_stall", {63'd0, AR_stall_o}, 64'd0);
    check("rst_err", {63'd0, err_id_mismatch_o}, 64'd0);

    // Unsplit 4-beat burst to master 1.
    push_ar(7'h25, 2'd0);
    send(7'h25, 4, 4, 1'b0);
    check("t1_fifo_empty", {63'd0, dut.u_tracker.w_empty}, 64'd1);

    // AR split into three 2-beat sub-bursts to master 2: RLAST only on beat 6.
    push_ar(7'h4A, 2'd2);
    send(7'h4A, 6, 2, 1'b1);
    check("t2_fifo_empty", {63'd0, dut.u_tracker.w_empty}, 64'd1);

    // Fill the info FIFO; a 9th push must be dropped.
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("t3_stall_pre", {63'd0, AR_stall_o}, 64'd0);
      push_ar({2'd1, 5'(i)}, 2'd0);
    end
    check("t3_stall_full", {63'd0, AR_stall_o}, 64'd1);
    push_ar({2'd1, 5'd8}, 2'd0);
    check("t3_stall_9th", {63'd0, AR_stall_o}, 64'd1);
    send({2'd1, 5'd0}, 1, 1, 1'b0);
    check("t3_stall_clear", {63'd0, AR_stall_o}, 64'd0);
    for (int i = 1; i < 8; i++) send({2'd1, 5'(i)}, 1, 1, 1'b0);
    check("t3_9th_ignored", {63'd0, dut.u_tracker.w_empty}, 64'd1);

    // Master 0 stalls 5 cycles mid-burst with continuous slave traffic.
    push_ar(7'h03, 2'd0);
    saw_low = 0; st_m = 0; st_from = cyc + 3; st_to = cyc + 8;
    send(7'h03, 8, 8, 1'b0);
    st_from = -1; st_to = -1;
    check("t4_sready_dropped", {63'd0, saw_low}, 64'd1);

`ifdef SA_R_ID_CHECK_EN
    // Head AxID 0x25, RID 0x26: one-cycle error pulse after the handshake.
    push_ar(7'h25, 2'd0);
    s_RID_i = 7'h26; s_RDATA_i = 64'h1234; s_RRESP_i = 2'd0; s_RLAST_i = 1'b1;
    cur_exp_rlast = 1'b1; s_RVALID_i = 1'b1;
    step(a);
    s_RVALID_i = 1'b0;
    check("t6_err_before", {63'd0, err_id_mismatch_o}, 64'd0);
    step(a);
    check("t6_err_pulse", {63'd0, err_id_mismatch_o}, 64'd1);
    step(a);
    check("t6_err_after", {63'd0, err_id_mismatch_o}, 64'd0);
    drain();
`endif

    // MST_AMT=3: mst_id 3 is sunk without RVALID while readies are low.
    b_dsp_RREADY_i = 3'b000;
    b_s_RID_i = {2'd3, 5'd1}; b_s_RLAST_i = 1'b1; b_s_RDATA_i = 64'hDEAD; b_s_RVALID_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t5_sunk_rvalid", {61'd0, b_dsp_RVALID_o}, 64'd0);
      check("t5_sready_flow", {63'd0, b_s_RREADY_o}, 64'd1);
    end
    b_dsp_RREADY_i = 3'b111;
    b_s_RID_i = {2'd2, 5'd7}; b_s_RDATA_i = 64'hBEEF;
    @(posedge clk); #1;
    b_s_RVALID_i = 1'b0;
    check("t5_route_m2", {61'd0, b_dsp_RVALID_o}, 64'd4);
    check("t5_route_rid", {59'd0, b_dsp_RID_o[14:10]}, 64'd7);
    $display("beat dut_b mst=2 rid=07 rvalid=%b", b_dsp_RVALID_o);
    @(posedge clk); #1;
    check("t5_idle", {61'd0, b_dsp_RVALID_o}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
